// File: rtl/fetch_sequencer.sv
// Fetch-stage redirect sequencer with a return-address stack (RAS).
// Define RAS_OVERFLOW_WRAP_EN to make a push on a full stack overwrite the oldest entry instead of dropping the push.
module fetch_sequencer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             SIG_Jump,
  input  logic             SIG_Ret,
  input  logic             SIG_Bne,
  input  logic             SIG_Beq,
  input  logic             SIG_CallRs1,
  input  logic             SIG_Call,
  input  logic             SIG_Eq,
  input  logic [WIDTH-1:0] pc4,
  output logic [2:0]       pc_source,
  output logic             kill,
  output logic             pc_enable,
  output logic [WIDTH-1:0] ret_address,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             fault,
  output logic [7:0]       stall_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  localparam logic [2:0] SRC_PC4  = 3'd0;
  localparam logic [2:0] SRC_JUMP = 3'd1;
  localparam logic [2:0] SRC_BR   = 3'd2;
  localparam logic [2:0] SRC_RS1  = 3'd3;
  localparam logic [2:0] SRC_RET  = 3'd4;

  typedef enum logic [1:0] {RUN, STALL, FAULT} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    sp_q, sp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             fault_q, fault_d;
  logic [7:0]       stall_cnt_q, stall_cnt_d;
  logic [WIDTH-1:0] entry_q [DEPTH];

  logic          accept;
  logic          taken;
  logic          push_req;
  logic          pop_req;
  logic          ret_fault;
  logic          push_do;
  logic [PW-1:0] top_ptr;

  // Gating with reset keeps every combinational output quiet while reset is held low.
  assign accept    = reset && (state_q == RUN) && !stall;
  assign taken     = (SIG_Beq && SIG_Eq) || (SIG_Bne && !SIG_Eq);
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == CNT_FULL);
  assign push_req  = accept && !SIG_Ret && (SIG_Call || SIG_CallRs1);
  assign pop_req   = accept && SIG_Ret && !ras_empty;
  assign ret_fault = accept && SIG_Ret && ras_empty;
  assign top_ptr   = sp_q - PTR_ONE;

  assign pc_enable    = accept;
  assign ret_address  = ras_empty ? '0 : entry_q[top_ptr];
  assign ras_overflow = ovf_q;
  assign fault        = fault_q;
  assign stall_count  = stall_cnt_q;

  always_comb begin
    pc_source = SRC_PC4;
    kill      = (state_q == FAULT);
    if (accept) begin
      if (SIG_Ret) begin
        pc_source = ras_empty ? SRC_PC4 : SRC_RET;
        kill      = 1'b1;
      end else if (SIG_CallRs1) begin
        pc_source = SRC_RS1;
        kill      = 1'b1;
      end else if (SIG_Call || SIG_Jump) begin
        pc_source = SRC_JUMP;
        kill      = 1'b1;
      end else if (taken) begin
        pc_source = SRC_BR;
        kill      = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    fault_d     = fault_q;
    stall_cnt_d = stall_cnt_q;
    push_do     = 1'b0;

    if (stall && (state_q != FAULT) && (stall_cnt_q != 8'hFF))
      stall_cnt_d = stall_cnt_q + 8'd1;

    case (state_q)
      RUN: begin
        if (stall) begin
          state_d = STALL;
        end else if (ret_fault) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end
      end
      STALL: begin
        if (!stall) state_d = RUN;
      end
      default: state_d = FAULT;
    endcase

    if (pop_req) begin
      sp_d    = sp_q - PTR_ONE;
      count_d = count_q - CNT_ONE;
    end else if (push_req) begin
      if (!ras_full) begin
        push_do = 1'b1;
        sp_d    = sp_q + PTR_ONE;
        count_d = count_q + CNT_ONE;
      end else begin
`ifdef RAS_OVERFLOW_WRAP_EN
        // When full, sp already points at the oldest slot, so the write replaces it.
        push_do = 1'b1;
        sp_d    = sp_q + PTR_ONE;
`else
        ovf_d   = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      sp_q        <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      fault_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      fault_q     <= fault_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Stack storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_do) entry_q[sp_q] <= pc4;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized bench for fetch_sequencer, checked against a queue-based reference model.
module tb_fetch_sequencer;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             stall = 1'b0;
  logic             SIG_Jump = 1'b0, SIG_Ret = 1'b0, SIG_Bne = 1'b0, SIG_Beq = 1'b0;
  logic             SIG_CallRs1 = 1'b0, SIG_Call = 1'b0, SIG_Eq = 1'b0;
  logic [WIDTH-1:0] pc4 = '0;
  logic [2:0]       pc_source;
  logic             kill, pc_enable, ras_empty, ras_full, ras_overflow, fault;
  logic [WIDTH-1:0] ret_address;
  logic [7:0]       stall_count;

  fetch_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .SIG_Jump(SIG_Jump), .SIG_Ret(SIG_Ret), .SIG_Bne(SIG_Bne), .SIG_Beq(SIG_Beq),
    .SIG_CallRs1(SIG_CallRs1), .SIG_Call(SIG_Call), .SIG_Eq(SIG_Eq),
    .pc4(pc4), .pc_source(pc_source), .kill(kill), .pc_enable(pc_enable),
    .ret_address(ret_address), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .fault(fault), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: mode 0 = running, 1 = stalled, 2 = faulted.
  int          m_mode = 0;
  logic [31:0] m_stk[$];
  bit          m_ovf = 0;
  bit          m_fault = 0;
  int          m_scnt = 0;

  logic [31:0] o_src, o_kill, o_en, o_ret, o_empty, o_full, o_ovf, o_fault, o_scnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_mode = 0;
    m_stk.delete();
    m_ovf = 0;
    m_fault = 0;
    m_scnt = 0;
  endtask

  task automatic step(input bit st, jmp, ret, bne, beq, crs1, call, eq, input logic [31:0] p4);
    bit acc, empty, bad, tk, ekill;
    logic [2:0] esrc;
    @(negedge clk);
    stall = st; SIG_Jump = jmp; SIG_Ret = ret; SIG_Bne = bne; SIG_Beq = beq;
    SIG_CallRs1 = crs1; SIG_Call = call; SIG_Eq = eq; pc4 = p4;
    #2;
    empty = (m_stk.size() == 0);
    acc   = (m_mode == 0) && !st;
    tk    = (beq && eq) || (bne && !eq);
    esrc  = 3'd0;
    bad   = 0;
    if (acc) begin
      if (ret) begin
        if (empty) bad = 1; else esrc = 3'd4;
      end else if (crs1) esrc = 3'd3;
      else if (call || jmp) esrc = 3'd1;
      else if (tk) esrc = 3'd2;
    end
    ekill = (m_mode == 2) || bad || (esrc != 3'd0);
    o_src = 32'(pc_source); o_kill = 32'(kill); o_en = 32'(pc_enable); o_ret = ret_address;
    o_empty = 32'(ras_empty); o_full = 32'(ras_full); o_ovf = 32'(ras_overflow);
    o_fault = 32'(fault); o_scnt = 32'(stall_count);
    chk("pc_source", o_src, 32'(esrc));
    chk("kill", o_kill, 32'(ekill));
    chk("pc_enable", o_en, 32'(acc));
    chk("ret_address", o_ret, empty ? 32'h0 : m_stk[$]);
    chk("ras_empty", o_empty, 32'(empty));
    chk("ras_full", o_full, 32'(m_stk.size() == DEPTH));
    chk("ras_overflow", o_ovf, 32'(m_ovf));
    chk("fault", o_fault, 32'(m_fault));
    chk("stall_count", o_scnt, 32'(m_scnt));
    @(posedge clk);
    if (st && m_mode != 2 && m_scnt < 255) m_scnt++;
    if (acc) begin
      if (ret) begin
        if (empty) m_fault = 1;
        else void'(m_stk.pop_back());
      end else if (call || crs1) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(p4);
        else begin
`ifdef RAS_OVERFLOW_WRAP_EN
          void'(m_stk.pop_front());
          m_stk.push_back(p4);
`else
          m_ovf = 1;
`endif
        end
      end
    end
    if (m_mode == 0) begin
      if (st) m_mode = 1;
      else if (bad) m_mode = 2;
    end else if (m_mode == 1) begin
      if (!st) m_mode = 0;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic do_reset(input bit mid_push);
    @(negedge clk);
    stall = 0; SIG_Jump = 0; SIG_Ret = 0; SIG_Bne = 0; SIG_Beq = 0;
    SIG_CallRs1 = 0; SIG_Call = mid_push; SIG_Eq = 0; pc4 = 32'hDEAD_0000 | $urandom_range(0, 255);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_pc_source", 32'(pc_source), 32'h0);
    chk("rst_kill", 32'(kill), 32'h0);
    chk("rst_pc_enable", 32'(pc_enable), 32'h0);
    chk("rst_ret_address", ret_address, 32'h0);
    chk("rst_ras_empty", 32'(ras_empty), 32'h1);
    chk("rst_ras_full", 32'(ras_full), 32'h0);
    chk("rst_ras_overflow", 32'(ras_overflow), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_stall_count", 32'(stall_count), 32'h0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    SIG_Call = 0;
    reset = 1'b1;
  endtask

  initial begin
    do_reset(0);

    // Single call then return
    step(0, 0, 0, 0, 0, 0, 1, 0, 32'h10);
    chk("r34_src", o_src, 32'h1);
    chk("r34_kill", o_kill, 32'h1);
    idle();
    chk("r34_ret", o_ret, 32'h10);
    chk("r34_empty", o_empty, 32'h0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 32'h0);
    chk("r34_pop_src", o_src, 32'h4);

    // Nested calls unwind in LIFO order
    step(0, 0, 0, 0, 0, 0, 1, 0, 32'h10);
    step(0, 0, 0, 0, 0, 0, 1, 0, 32'h20);
    step(0, 0, 0, 0, 0, 0, 1, 0, 32'h30);
    step(0, 0, 1, 0, 0, 0, 0, 0, 32'h0);
    chk("r35_src0", o_src, 32'h4);
    chk("r35_ret0", o_ret, 32'h30);
    step(0, 0, 1, 0, 0, 0, 0, 0, 32'h0);
    chk("r35_src1", o_src, 32'h4);
    chk("r35_ret1", o_ret, 32'h20);
    step(0, 0, 1, 0, 0, 0, 0, 0, 32'h0);
    chk("r35_src2", o_src, 32'h4);
    chk("r35_ret2", o_ret, 32'h10);
    idle();
    chk("r35_empty", o_empty, 32'h1);

    // Ret and Call together: pop only
    step(0, 0, 0, 0, 0, 0, 1, 0, 32'h44);
    step(0, 0, 1, 0, 0, 0, 1, 0, 32'h88);
    chk("r36_src", o_src, 32'h4);
    idle();
    chk("r36_empty", o_empty, 32'h1);

    // Stall holds a taken branch
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 1, 0, 0, 1, 32'h0);
      chk("r37_en_stall", o_en, 32'h0);
      chk("r37_src_stall", o_src, 32'h0);
    end
    step(0, 0, 0, 0, 1, 0, 0, 1, 32'h0);
    chk("r37_scnt", o_scnt, 32'h3);
    step(0, 0, 0, 0, 1, 0, 0, 1, 32'h0);
    chk("r37_src_br", o_src, 32'h2);
    chk("r37_kill_br", o_kill, 32'h1);

    // Overflow on the ninth call
    do_reset(0);
    for (int i = 1; i <= 9; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 32'(i * 32'h100));
    idle();
    chk("r38_full", o_full, 32'h1);
`ifdef RAS_OVERFLOW_WRAP_EN
    chk("r38_top", o_ret, 32'h900);
    chk("r38_ovf", o_ovf, 32'h0);
`else
    chk("r38_top", o_ret, 32'h800);
    chk("r38_ovf", o_ovf, 32'h1);
`endif

    // Return on empty stack faults until reset
    do_reset(0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 32'h0);
    chk("r39_src", o_src, 32'h0);
    chk("r39_kill", o_kill, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      chk("r39_fault", o_fault, 32'h1);
      chk("r39_kill_hold", o_kill, 32'h1);
      chk("r39_en_hold", o_en, 32'h0);
    end
    do_reset(0);
    idle();
    chk("r39_run_en", o_en, 32'h1);
    chk("r39_fault_clr", o_fault, 32'h0);

    // Reset during a push discards it
    do_reset(1);
    idle();
    chk("midpush_empty", o_empty, 32'h1);

    // Stall counter saturates
    for (int i = 0; i < 260; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    idle();
    chk("scnt_sat", o_scnt, 32'hFF);

    // Randomized traffic
    do_reset(0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset(1'($urandom));
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 3) == 0, 1'($urandom), $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
